// File: rtl/regfile_pkg.sv
// Shared constants and types for the RV32I architectural register file.
package regfile_pkg;

   localparam int RegBus     = 32;
   localparam int RegAddrBus = 5;
   localparam int RegNum     = 32;

   localparam logic [RegBus-1:0]     ZeroWord    = '0;
   localparam logic                  WriteEnable = 1'b1;
   localparam logic                  ReadEnable  = 1'b1;
   localparam logic                  RstEnable   = 1'b1;
   localparam logic [RegAddrBus-1:0] NOPRegAddr  = '0;

   // Where a read port takes its data from in the current cycle.
   typedef enum logic [1:0] {
      SRC_ZERO,
      SRC_BYPASS,
      SRC_REG
   } rdSrc_e;

endpackage

// File: rtl/regfile_if.sv
// Register-file bus: write-back write port plus the decode stage's two read ports.
interface regfile_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
);

   logic              we;
   logic [ADDR_W-1:0] waddr;
   logic [DATA_W-1:0] wdata;

   logic              re1;
   logic [ADDR_W-1:0] raddr1;
   logic [DATA_W-1:0] rdata1;
   logic              uninit1;

   logic              re2;
   logic [ADDR_W-1:0] raddr2;
   logic [DATA_W-1:0] rdata2;
   logic              uninit2;

   modport master (
      output we, waddr, wdata,
      output re1, raddr1, re2, raddr2,
      input  rdata1, uninit1, rdata2, uninit2
   );

   modport slave (
      input  we, waddr, wdata,
      input  re1, raddr1, re2, raddr2,
      output rdata1, uninit1, rdata2, uninit2
   );

endinterface

// File: rtl/regfile_rd_port.sv
// One combinational read port: zero gating, write-through bypass and uninit flag.
module regfile_rd_port
   import regfile_pkg::*;
#(
   parameter int DATA_W = RegBus,
   parameter int ADDR_W = RegAddrBus
) (
   input  logic              rst_i,
   input  logic              re_i,
   input  logic [ADDR_W-1:0] raddr_i,
   input  logic [DATA_W-1:0] regData_i,
   input  logic              written_i,
   input  logic              we_i,
   input  logic [ADDR_W-1:0] waddr_i,
   input  logic [DATA_W-1:0] wdata_i,
   output logic [DATA_W-1:0] rdata_o,
   output logic              uninit_o
);

   rdSrc_e src;
   logic   bypassHit;

   assign bypassHit = (we_i == WriteEnable) && (waddr_i == raddr_i)
                      && (raddr_i != ADDR_W'(NOPRegAddr));

   // Reset, a disabled port and x0 all force zero; otherwise a same-cycle write wins over storage.
   always_comb begin
      src = SRC_REG;
      if ((rst_i == RstEnable) || (re_i != ReadEnable) || (raddr_i == ADDR_W'(NOPRegAddr))) begin
         src = SRC_ZERO;
      end else if (bypassHit) begin
         src = SRC_BYPASS;
      end
   end

   always_comb begin
      rdata_o = '0;
      case (src)
         SRC_ZERO:   rdata_o = '0;
         SRC_BYPASS: rdata_o = wdata_i;
         SRC_REG:    rdata_o = regData_i;
         default:    rdata_o = '0;
      endcase
   end

   assign uninit_o = (re_i == ReadEnable) && (rst_i != RstEnable) && !written_i && !bypassHit;

endmodule

// File: rtl/regfile.sv
// RV32I 32x32 register file with a written-since-reset bitmap and two read ports.
// Optional write log (wr_count_o, last_waddr_o, last_wdata_o) enabled by REGFILE_WR_LOG_EN.
module regfile
   import regfile_pkg::*;
#(
   parameter int DATA_W   = RegBus,
   parameter int ADDR_W   = RegAddrBus,
   parameter int NUM_REGS = RegNum
) (
   input  logic              clk,
   input  logic              rst,
`ifdef REGFILE_WR_LOG_EN
   output logic [31:0]       wr_count_o,
   output logic [ADDR_W-1:0] last_waddr_o,
   output logic [DATA_W-1:0] last_wdata_o,
`endif
   regfile_if.slave          bus
);

   logic [DATA_W-1:0]   regs_q [NUM_REGS];
   logic [DATA_W-1:0]   regs_d [NUM_REGS];
   logic [NUM_REGS-1:0] written_q;
   logic [NUM_REGS-1:0] written_d;
   logic                commit;

   // A write only lands outside reset and never in x0.
   assign commit = (rst != RstEnable) && (bus.we == WriteEnable)
                   && (bus.waddr != ADDR_W'(NOPRegAddr));

   always_comb begin
      regs_d    = regs_q;
      written_d = written_q;
      if (commit) begin
         regs_d[bus.waddr]    = bus.wdata;
         written_d[bus.waddr] = 1'b1;
      end
   end

   // Bit 0 of the bitmap is held at 1 so reads of x0 never flag as uninitialised.
   always_ff @(posedge clk) begin
      if (rst == RstEnable) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            regs_q[i] <= '0;
         end
         written_q <= NUM_REGS'(1);
      end else begin
         regs_q    <= regs_d;
         written_q <= written_d;
      end
   end

   regfile_rd_port #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
   ) u_rdPort1 (
      .rst_i     (rst),
      .re_i      (bus.re1),
      .raddr_i   (bus.raddr1),
      .regData_i (regs_q[bus.raddr1]),
      .written_i (written_q[bus.raddr1]),
      .we_i      (bus.we),
      .waddr_i   (bus.waddr),
      .wdata_i   (bus.wdata),
      .rdata_o   (bus.rdata1),
      .uninit_o  (bus.uninit1)
   );

   regfile_rd_port #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
   ) u_rdPort2 (
      .rst_i     (rst),
      .re_i      (bus.re2),
      .raddr_i   (bus.raddr2),
      .regData_i (regs_q[bus.raddr2]),
      .written_i (written_q[bus.raddr2]),
      .we_i      (bus.we),
      .waddr_i   (bus.waddr),
      .wdata_i   (bus.wdata),
      .rdata_o   (bus.rdata2),
      .uninit_o  (bus.uninit2)
   );

`ifdef REGFILE_WR_LOG_EN
   logic [31:0]       wrCount_q, wrCount_d;
   logic [ADDR_W-1:0] lastWaddr_q, lastWaddr_d;
   logic [DATA_W-1:0] lastWdata_q, lastWdata_d;

   always_comb begin
      wrCount_d   = wrCount_q;
      lastWaddr_d = lastWaddr_q;
      lastWdata_d = lastWdata_q;
      if (commit) begin
         wrCount_d   = wrCount_q + 32'd1;
         lastWaddr_d = bus.waddr;
         lastWdata_d = bus.wdata;
      end
   end

   // The counter wraps naturally through 32-bit addition.
   always_ff @(posedge clk) begin
      if (rst == RstEnable) begin
         wrCount_q   <= '0;
         lastWaddr_q <= '0;
         lastWdata_q <= '0;
      end else begin
         wrCount_q   <= wrCount_d;
         lastWaddr_q <= lastWaddr_d;
         lastWdata_q <= lastWdata_d;
      end
   end

   assign wr_count_o   = wrCount_q;
   assign last_waddr_o = lastWaddr_q;
   assign last_wdata_o = lastWdata_q;
`endif

endmodule
